// File: rtl/interval_meter.sv
// -----------------------------------------------------------------------------
// interval_meter
//
// Cycle-accurate stopwatch. Counts the clock edges between the edge that
// samples start=1 and the edge that samples stop=1, then reports that count.
// It is the capture-side counterpart of a countdown timer: driving stop from
// the timer's done and starting both together returns the programmed count.
// The counter saturates at all ones; a measurement that runs past the
// maximum reports result=all ones with overflow=1. A stop and a start on
// the same edge close one measurement and open the next, so no cycles are
// lost between them.
//
// Optional feature (macro INTERVAL_METER_MINMAX_EN):
//   Adds running minimum/maximum of completed intervals, cleared by stats_clr.
//
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   start      in   begin (or restart) a measurement
//   stop       in   end the measurement in progress
//   abort      in   discard the measurement in progress, return to IDLE
//   stats_clr  in   (MINMAX only) reset min_o to all ones and max_o to 0
//   busy       out  measurement in progress
//   result     out  last completed interval in cycles, held until next valid
//   valid      out  one-cycle pulse: result/overflow just updated
//   overflow   out  last completed interval exceeded 2^WIDTH-1
//   min_o      out  (MINMAX only) smallest completed interval since clear
//   max_o      out  (MINMAX only) largest completed interval since clear
// -----------------------------------------------------------------------------
module interval_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
`ifdef INTERVAL_METER_MINMAX_EN
  input  logic             stats_clr,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic             ovf_pending;

  // Priority per edge: abort > stop > start. The counter starts at 1 on the
  // start edge so that at the stop edge it already equals the interval.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      counter     <= '0;
      ovf_pending <= 1'b0;
      result      <= '0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else if (state == RUN) begin
        if (stop) begin
          result   <= counter;
          overflow <= ovf_pending;
          valid    <= 1'b1;
          if (start) begin
            // back-to-back: this edge is also the origin of the next interval
            counter     <= ONE;
            ovf_pending <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end else if (start) begin
          counter     <= ONE;
          ovf_pending <= 1'b0;
        end else if (counter == ALL_ONES) begin
          // increment would wrap: hold at all ones and remember the overflow
          ovf_pending <= 1'b1;
        end else begin
          counter <= counter + ONE;
        end
      end else if (start) begin
        state       <= RUN;
        counter     <= ONE;
        ovf_pending <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);

`ifdef INTERVAL_METER_MINMAX_EN
  // A measurement completes on the same edge that raises valid.
  logic             complete;
  logic [WIDTH-1:0] new_val;

  assign complete = (state == RUN) && stop && !abort;
  assign new_val  = ovf_pending ? ALL_ONES : counter;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_o <= ALL_ONES;
      max_o <= '0;
    end else if (stats_clr) begin
      // a clear coinciding with a completion seeds both with the new interval
      min_o <= complete ? new_val : ALL_ONES;
      max_o <= complete ? new_val : '0;
    end else if (complete) begin
      if (new_val < min_o) min_o <= new_val;
      if (new_val > max_o) max_o <= new_val;
    end
  end
`endif

endmodule

// File: tb/tb_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_interval_meter
//
// Two instances (WIDTH=8 and WIDTH=4) share one stimulus stream. A model
// remembers the edge number of the last start and derives each interval as a
// plain difference of edge numbers, saturated to the instance's maximum. One
// process compares every output of both instances against the model after
// every edge; the directed sequences add literal expected values.
// -----------------------------------------------------------------------------
module tb_interval_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop_drv = 1'b0, abort = 1'b0, stats_clr = 1'b0;
  logic loop_mode = 1'b0;
  logic stop_mux;

  logic       busy8, valid8, ovf8;
  logic [7:0] res8;
  logic       busy4, valid4, ovf4;
  logic [3:0] res4;
  logic [7:0] min8, max8;
  logic [3:0] min4, max4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Small countdown timer for the loopback test: loaded with 25 on the start
  // edge, done is sampled high on the edge the delay expires.
  logic [7:0] tcnt = 8'd0;
  always @(posedge clk) begin
    if (start) tcnt <= 8'd25;
    else if (tcnt != 8'd0) tcnt <= tcnt - 8'd1;
  end
  assign stop_mux = loop_mode ? (tcnt == 8'd1) : stop_drv;

  interval_meter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start(start), .stop(stop_mux), .abort(abort),
`ifdef INTERVAL_METER_MINMAX_EN
    .stats_clr(stats_clr), .min_o(min8), .max_o(max8),
`endif
    .busy(busy8), .result(res8), .valid(valid8), .overflow(ovf8)
  );

  interval_meter #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start(start), .stop(stop_mux), .abort(abort),
`ifdef INTERVAL_METER_MINMAX_EN
    .stats_clr(stats_clr), .min_o(min4), .max_o(max4),
`endif
    .busy(busy4), .result(res4), .valid(valid4), .overflow(ovf4)
  );

`ifndef INTERVAL_METER_MINMAX_EN
  assign min8 = 8'hFF; assign max8 = 8'h00;
  assign min4 = 4'hF;  assign max4 = 4'h0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int  maxv[2] = '{255, 15};
  int  cyc = 0;
  bit  m_run[2];
  int  m_t0[2];
  int  m_res[2];
  bit  m_ovf[2];
  bit  m_vld[2];
  int  m_min[2];
  int  m_max[2];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_run[i] = 0; m_res[i] = 0; m_ovf[i] = 0; m_vld[i] = 0;
          m_min[i] = maxv[i]; m_max[i] = 0;
        end else begin
          m_vld[i] = 0;
          if (abort) begin
            m_run[i] = 0;
          end else if (m_run[i] && stop_mux) begin
            int n;
            n = cyc - m_t0[i];
            m_ovf[i] = (n > maxv[i]);
            m_res[i] = m_ovf[i] ? maxv[i] : n;
            m_vld[i] = 1;
            if (start) m_t0[i] = cyc;
            else m_run[i] = 0;
          end else if (start) begin
            m_run[i] = 1;
            m_t0[i] = cyc;
          end
          if (stats_clr) begin
            m_min[i] = m_vld[i] ? m_res[i] : maxv[i];
            m_max[i] = m_vld[i] ? m_res[i] : 0;
          end else if (m_vld[i]) begin
            if (m_res[i] < m_min[i]) m_min[i] = m_res[i];
            if (m_res[i] > m_max[i]) m_max[i] = m_res[i];
          end
        end
      end
      #1;
      chk("busy8", busy8, m_run[0]);   chk("busy4", busy4, m_run[1]);
      chk("valid8", valid8, m_vld[0]); chk("valid4", valid4, m_vld[1]);
      chk("result8", res8, m_res[0]);  chk("result4", res4, m_res[1]);
      chk("ovf8", ovf8, m_ovf[0]);     chk("ovf4", ovf4, m_ovf[1]);
`ifdef INTERVAL_METER_MINMAX_EN
      chk("min8", min8, m_min[0]);     chk("min4", min4, m_min[1]);
      chk("max8", max8, m_max[0]);     chk("max4", max4, m_max[1]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic p, input logic a, input logic c);
    @(negedge clk);
    start = s; stop_drv = p; abort = a; stats_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  // start at E0, stop at Ek
  task automatic meas(input int k);
    step(1, 0, 0, 0);
    idle(k - 1);
    step(0, 1, 0, 0);
    $display("measure %0d: result8=%0d ovf8=%0d result4=%0d ovf4=%0d", k, res8, ovf8, res4, ovf4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0); chk("rst_result", res8, 0);
    chk("rst_valid", valid8, 0); chk("rst_ovf", ovf8, 0);
    @(negedge clk); rst_n = 1'b1;

    // start E0, stop E10
    meas(10);
    chk("t1_valid", valid8, 1); chk("t1_result", res8, 10);
    chk("t1_ovf", ovf8, 0);     chk("t1_busy", busy8, 0);
    idle(1);
    chk("t1_valid_drop", valid8, 0); chk("t1_hold", res8, 10);

    // loopback against the countdown timer, count 25
    loop_mode = 1'b1;
    step(1, 0, 0, 0);
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(0, 0, 0, 0);
      if (valid8) got = 1;
    end
    chk("loop_seen", got, 1); chk("loop_result", res8, 25);
    $display("loopback: result8=%0d", res8);
    loop_mode = 1'b0;
    idle(2);

    // WIDTH=4 saturation: stop at E20, then a 3-cycle interval
    meas(20);
    chk("sat_result4", res4, 15); chk("sat_ovf4", ovf4, 1);
    chk("sat_result8", res8, 20); chk("sat_ovf8", ovf8, 0);
    meas(15);
    chk("edge15_result4", res4, 15); chk("edge15_ovf4", ovf4, 0);
    meas(16);
    chk("edge16_ovf4", ovf4, 1);
    meas(3);
    chk("after_sat_result4", res4, 3); chk("after_sat_ovf4", ovf4, 0);

    // back-to-back: start E0, stop+start E5, stop E12
    step(1, 0, 0, 0);
    idle(4);
    step(1, 1, 0, 0);
    $display("b2b first: valid8=%0d result8=%0d busy8=%0d", valid8, res8, busy8);
    chk("b2b1_valid", valid8, 1); chk("b2b1_result", res8, 5); chk("b2b1_busy", busy8, 1);
    idle(6);
    step(0, 1, 0, 0);
    $display("b2b second: valid8=%0d result8=%0d", valid8, res8);
    chk("b2b2_valid", valid8, 1); chk("b2b2_result", res8, 7);

    // abort at E4, stop at E6
    step(1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0);
    chk("abort_busy", busy8, 0);
    idle(1);
    step(0, 1, 0, 0);
    $display("abort: valid8=%0d result8=%0d", valid8, res8);
    chk("abort_valid", valid8, 0); chk("abort_hold", res8, 7);

    // stop+start every cycle: each valid carries 1
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0);
      $display("repeat %0d: valid8=%0d result8=%0d", k, valid8, res8);
      chk("rep_valid", valid8, 1); chk("rep_result", res8, 1);
    end
    step(0, 1, 0, 0);
    chk("rep_last", res8, 1);

    // min/max statistics
    step(0, 0, 0, 1);
    meas(7); meas(3); meas(12);
`ifdef INTERVAL_METER_MINMAX_EN
    chk("mm_min", min8, 3); chk("mm_max", max8, 12);
    step(0, 0, 0, 1);
    chk("clr_min", min8, 255); chk("clr_max", max8, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    chk("clr_stop_min", min8, 1); chk("clr_stop_max", max8, 1);
`endif

    // asynchronous reset mid-RUN
    step(1, 0, 0, 0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: busy8=%0d result8=%0d", busy8, res8);
    chk("arst_busy", busy8, 0); chk("arst_result", res8, 0); chk("arst_valid", valid8, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    meas(2);
    chk("post_rst_result", res8, 2);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
